fetch_queue_wbp: RTL and testbench
==================================

Name: fetch_queue_wbp

Overview:
- Instruction-fetch frontend for the next-generation core: pipelined Wishbone (B4) controller with a parametrised prefetch queue.
- Issues back-to-back sequential fetches without waiting for each ack, buffers returned words with their PCs, and hands them to decode through a valid/ready interface.
- Supports single-cycle redirect (branch/jump/trap) with no bus drain bubble; stale in-flight responses are discarded by counter.

Parameters:
- DEPTH, 4, queue entries; power of two, >= 2
- MAX_OUTSTANDING, 4, maximum accepted-but-unacked bus requests; 1..DEPTH
- ERR_HALT, 1, 1 = stop issuing after a bus error until the next redirect; 0 = keep fetching

Ports:
- i_clk  input  1  clock
- i_rst  input  1  synchronous active-high reset
- i_init_pc  input  32  fetch PC loaded while i_rst is high
- i_redirect  input  1  flush the queue and restart fetch at i_redirect_pc
- i_redirect_pc  input  32  new fetch address; bits [1:0] ignored
- o_valid  output  1  queue head is valid
- i_ready  input  1  consumer accepts the head this cycle
- o_instr  output  32  head instruction word
- o_pc  output  32  head PC
- o_error  output  1  head entry returned with bus error
- o_wb_cyc  output  1  Wishbone cycle
- o_wb_stb  output  1  Wishbone strobe
- o_wb_we  output  1  tied 0
- o_wb_sel  output  4  tied 4'b1111
- o_wb_adr  output  32  byte address, [1:0]=0
- i_wb_dat  input  32  read data
- i_wb_ack  input  1  acknowledge
- i_wb_err  input  1  error (treated as a terminating ack)
- i_wb_stall  input  1  slave cannot accept the request this cycle

Behaviour:
- Reset: queue empty, outstanding=0, discard=0, halted=0, fetch_pc={i_init_pc[31:2],2'b00}, resp_pc=fetch_pc. Outputs o_valid=0, o_error=0, o_wb_cyc=0, o_wb_stb=0, o_wb_adr=0. Reset overrides everything, including a mid-transaction state (responses arriving after reset are ignored; the slave is expected to be reset too).
- Counters are $clog2(DEPTH)+1 bits wide. live = outstanding - discard.
- Issue:
  - o_wb_stb = !halted && (outstanding < MAX_OUTSTANDING) && (count + live < DEPTH).
  - o_wb_adr = fetch_pc, driven registered or combinationally, but it must be stable while stb && stall.
  - Accept = stb && !i_wb_stall; on accept, fetch_pc += 4 (wraps modulo 2^32) and outstanding += 1.
- o_wb_cyc = o_wb_stb || (outstanding != 0). Deasserts the cycle after the last ack when no further request is pending.
- Response (i_wb_ack || i_wb_err, only counted while outstanding != 0):
  - outstanding -= 1.
  - If discard != 0: discard -= 1; nothing is pushed.
  - Otherwise push {i_wb_dat, resp_pc, i_wb_err} and resp_pc += 4.
  - err with ERR_HALT=1 sets halted. The pushed data on err is don't-care.
- Queue: show-ahead FIFO.
  - o_valid = count != 0. Pop when o_valid && i_ready.
  - Push and pop in the same cycle is legal at any occupancy, including full.
  - Overflow cannot occur because of the credit rule.
- Latency: accept at cycle N, ack at cycle M -> o_valid high at M+1. Zero-wait slave gives a sustained throughput of 1 instr/cycle when i_ready=1 and MAX_OUTSTANDING >= 2.
- Redirect (i_redirect=1 at an edge):
  - queue flushed (count=0); a pop in the same cycle is ignored.
  - fetch_pc = resp_pc = {i_redirect_pc[31:2],2'b00}; halted cleared.
  - discard = outstanding + accept_this_cycle - response_this_cycle. The request accepted in the redirect cycle carries the old address and is discarded.
  - o_wb_stb may assert with the new address on the very next cycle; cyc stays high across the redirect if outstanding != 0.
  - Back-to-back redirects accumulate discards correctly.
- The o_wb_stb request must not be withdrawn while i_wb_stall=1, except on a redirect or reset.

Test Plan:
- Zero-wait slave, init_pc=0x1000_0000, i_ready=1: addresses 0x1000_0000, _0004, _0008... issued every cycle; o_pc sequence matches; one instr/cycle after a 2-cycle initial latency.
- i_ready=0 with DEPTH=4: exactly 4 requests accepted, then stb low; queue full; raise i_ready -> 4 words in order, then fetch resumes at +0x10.
- 3-cycle-latency slave with 3 outstanding, redirect to 0x2000_0042: 3 stale acks produce no o_valid; next o_pc=0x2000_0040; new request issued the cycle after the redirect.
- i_wb_stall held 5 cycles on the request to 0x1000_0008: o_wb_adr stable, no duplicate accept, fetch_pc advances only once.
- i_wb_err on the 0x1000_0004 response (ERR_HALT=1): head entry has o_error=1, stb stays low until a redirect to 0x3000_0000, then fetch resumes.
- Assert i_rst mid-burst with 2 outstanding: next cycle o_valid=0, cyc=0, stb=0; after release, fetch starts at i_init_pc.

Source files
------------

// File: rtl/fetch_queue_wbp.sv
// Instruction-fetch frontend: pipelined Wishbone B4 master feeding a show-ahead
// prefetch queue. Redirects flush the queue and drop in-flight responses by count.
module fetch_queue_wbp #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned ERR_HALT        = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_init_pc,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic        o_error,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [3:0]  o_wb_sel,
  output logic [31:0] o_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_ack,
  input  logic        i_wb_err,
  input  logic        i_wb_stall
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] MAX_W   = CW'(MAX_OUTSTANDING);

  typedef enum logic {
    FS_RUN,
    FS_HALT
  } fetch_state_t;

  fetch_state_t state_q, state_d;

  logic [31:0]   fetch_pc_q, resp_pc_q;
  logic [CW-1:0] outstanding_q, discard_q, count_q;
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic          stall_hold_q;

  logic [31:0] q_instr [DEPTH];
  logic [31:0] q_pc    [DEPTH];
  logic        q_err   [DEPTH];

  logic [CW-1:0] live, outstanding_d, discard_d;
  logic [CW:0]   credit_used;
  logic          issue_ok, stb, accept, resp, resp_live, push, pop;
  logic [31:0]   redirect_pc;

  always_comb begin
    redirect_pc   = i_redirect_pc & ~32'd3;
    live          = outstanding_q - discard_q;
    credit_used   = {1'b0, count_q} + {1'b0, live};
    issue_ok      = (state_q == FS_RUN) && (outstanding_q < MAX_W) && (credit_used < DEPTH_W);
    // a stalled request is held even if the halt flag rose meanwhile
    stb           = !i_rst && (stall_hold_q || issue_ok);
    accept        = stb && !i_wb_stall;
    resp          = !i_rst && (i_wb_ack || i_wb_err) && (outstanding_q != '0);
    resp_live     = resp && (discard_q == '0);
    push          = resp_live && !i_redirect;
    pop           = (count_q != '0) && i_ready && !i_redirect;
    outstanding_d = outstanding_q + CW'(accept) - CW'(resp);
    if (i_redirect) begin
      discard_d = outstanding_d;
    end else if (resp && (discard_q != '0)) begin
      discard_d = discard_q - CW'(1);
    end else begin
      discard_d = discard_q;
    end
  end

  always_comb begin
    state_d = state_q;
    if (i_redirect) begin
      state_d = FS_RUN;
    end else if (resp_live && i_wb_err && (ERR_HALT != 0)) begin
      state_d = FS_HALT;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= FS_RUN;
      fetch_pc_q    <= i_init_pc & ~32'd3;
      resp_pc_q     <= i_init_pc & ~32'd3;
      outstanding_q <= '0;
      discard_q     <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      stall_hold_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      stall_hold_q  <= stb && i_wb_stall && !i_redirect;
      if (i_redirect) begin
        fetch_pc_q <= redirect_pc;
        resp_pc_q  <= redirect_pc;
        count_q    <= '0;
        rd_ptr_q   <= '0;
        wr_ptr_q   <= '0;
      end else begin
        if (accept) begin
          fetch_pc_q <= fetch_pc_q + 32'd4;
        end
        if (push) begin
          resp_pc_q <= resp_pc_q + 32'd4;
          wr_ptr_q  <= wr_ptr_q + AW'(1);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + AW'(1);
        end
        count_q <= count_q + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      q_instr[wr_ptr_q] <= i_wb_dat;
      q_pc[wr_ptr_q]    <= resp_pc_q;
      q_err[wr_ptr_q]   <= i_wb_err;
    end
  end

  always_comb begin
    o_valid  = (count_q != '0);
    o_instr  = q_instr[rd_ptr_q];
    o_pc     = q_pc[rd_ptr_q];
    o_error  = o_valid && q_err[rd_ptr_q];
    o_wb_stb = stb;
    o_wb_cyc = stb || (!i_rst && (outstanding_q != '0));
    o_wb_we  = 1'b0;
    o_wb_sel = 4'b1111;
    o_wb_adr = stb ? fetch_pc_q : '0;
  end

endmodule

// File: tb/tb_fetch_queue_wbp.sv
// Bench for fetch_queue_wbp: pipelined slave model, sequential-PC scoreboard,
// directed scenarios followed by randomized redirects, stalls, latencies and errors.
module tb_fetch_queue_wbp;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned MAXO  = 4;

  logic clk = 1'b0;
  logic i_rst, i_redirect, i_ready, i_wb_ack, i_wb_err, i_wb_stall;
  logic [31:0] i_init_pc, i_redirect_pc, i_wb_dat;
  logic o_valid, o_error, o_wb_cyc, o_wb_stb, o_wb_we;
  logic [31:0] o_instr, o_pc, o_wb_adr;
  logic [3:0] o_wb_sel;

  always #5 clk = ~clk;

  fetch_queue_wbp #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .ERR_HALT(1)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_init_pc(i_init_pc),
    .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_valid(o_valid), .i_ready(i_ready), .o_instr(o_instr), .o_pc(o_pc), .o_error(o_error),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_sel(o_wb_sel),
    .o_wb_adr(o_wb_adr), .i_wb_dat(i_wb_dat), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
    .i_wb_stall(i_wb_stall)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: after reset/redirect to P the consumer sees P, P+4, P+8, ... with the
  // word the memory holds at each address and the error the memory reports there.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        err;
  } exp_t;
  exp_t sb[$];

  int unsigned err_mode = 0;
  logic [31:0] err_addr = '0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic err_at(input logic [31:0] a);
    if (err_mode == 1) return a == err_addr;
    if (err_mode == 2) return ((a >> 2) % 32'd29) == 32'd11;
    return 1'b0;
  endfunction

  task automatic expect_stream(input logic [31:0] start);
    logic [31:0] pc;
    pc = {start[31:2], 2'b00};
    sb.delete();
    for (int i = 0; i < 256; i++) begin
      sb.push_back('{word_at(pc), pc, err_at(pc)});
      pc += 32'd4;
    end
  endtask

  // Pipelined slave: in-order responses, per-request latency, optional stalls.
  typedef struct packed {
    logic [31:0] adr;
    int unsigned due;
  } pend_t;
  pend_t pend[$];

  int unsigned cyc_n = 0, last_due = 0;
  int unsigned lat_min = 1, lat_max = 1, stall_pct = 0, stall_left = 0;
  logic [31:0] stall_addr = 32'hFFFF_FFFF;
  int unsigned acc_total = 0, acc_stall = 0;
  logic hold_prev = 1'b0;
  logic [31:0] adr_prev = '0;

  initial begin : slave
    pend_t p;
    i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_stall = 1'b0; i_wb_dat = '0;
    forever begin
      @(negedge clk);
      cyc_n++;
      i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_dat = $urandom;
      if (pend.size() != 0 && pend[0].due <= cyc_n) begin
        p = pend.pop_front();
        if (err_at(p.adr)) i_wb_err = 1'b1;
        else i_wb_ack = 1'b1;
        i_wb_dat = word_at(p.adr);
      end
      #1;
      if (stall_left != 0 && o_wb_stb && o_wb_adr == stall_addr) begin
        i_wb_stall = 1'b1;
        stall_left--;
      end else begin
        i_wb_stall = ($urandom_range(99) < stall_pct);
      end
      if (hold_prev && !i_rst) begin
        check("stb_held", 32'(o_wb_stb), 32'd1);
        check("adr_held", o_wb_adr, adr_prev);
      end
      #1;
      if (i_rst) begin
        pend.delete();
        last_due  = cyc_n;
        hold_prev = 1'b0;
      end else begin
        if (o_wb_stb && !i_wb_stall) begin
          acc_total++;
          if (o_wb_adr == stall_addr) acc_stall++;
          p.adr = o_wb_adr;
          p.due = cyc_n + $urandom_range(lat_max, lat_min);
          if (p.due <= last_due) p.due = last_due + 1;
          last_due = p.due;
          pend.push_back(p);
        end
        hold_prev = o_wb_stb && i_wb_stall && !i_redirect;
        adr_prev  = o_wb_adr;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (!i_rst && o_valid && i_ready && !i_redirect) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_empty: got pc %08h want no output", o_pc);
        end else begin
          e = sb.pop_front();
          check("pc", o_pc, e.pc);
          check("err", 32'(o_error), 32'(e.err));
          if (!e.err) check("instr", o_instr, e.instr);
        end
      end
    end
  end

  task automatic run(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input logic [31:0] pc);
    i_rst = 1'b1; i_redirect = 1'b0; i_init_pc = pc;
    expect_stream(pc);
    run(1);
    #4;
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_error", 32'(o_error), 32'd0);
    check("rst_cyc", 32'(o_wb_cyc), 32'd0);
    check("rst_stb", 32'(o_wb_stb), 32'd0);
    check("rst_adr", o_wb_adr, 32'd0);
    run(1);
    i_rst = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] pc);
    i_redirect = 1'b1; i_redirect_pc = pc;
    expect_stream(pc);
    run(1);
    i_redirect = 1'b0;
  endtask

  initial begin : stim
    int unsigned n, a0;
    logic [31:0] t;
    i_rst = 1'b1; i_redirect = 1'b0; i_redirect_pc = '0; i_ready = 1'b1;
    i_init_pc = 32'h1000_0000;

    // zero-wait slave: 2-cycle first latency then one word per cycle
    lat_min = 1; lat_max = 1;
    do_reset(32'h1000_0000);
    #4;
    check("t1_valid0", 32'(o_valid), 32'd0);
    check("t1_adr0", o_wb_adr, 32'h1000_0000);
    run(1); #4; check("t1_valid1", 32'(o_valid), 32'd0);
    run(1); #4; check("t1_valid2", 32'(o_valid), 32'd1);
    n = 0;
    for (int i = 0; i < 16; i++) begin
      run(1); #4;
      if (o_valid && o_wb_stb) n++;
    end
    check("t1_rate", n, 32'd16);

    // consumer blocked: queue fills with exactly DEPTH requests
    run(1);
    i_ready = 1'b0;
    do_reset(32'h1000_0000);
    a0 = acc_total;
    run(12); #4;
    check("t2_accepts", acc_total - a0, 32'd4);
    check("t2_stb", 32'(o_wb_stb), 32'd0);
    check("t2_valid", 32'(o_valid), 32'd1);
    check("t2_head", o_pc, 32'h1000_0000);
    run(1);
    i_ready = 1'b1;
    run(1); #4;
    check("t2_resume_stb", 32'(o_wb_stb), 32'd1);
    check("t2_resume_adr", o_wb_adr, 32'h1000_0010);
    run(8);

    // 3-cycle slave, redirect with requests in flight
    lat_min = 3; lat_max = 3;
    do_reset(32'h1000_0000);
    run(9);
    redirect(32'h2000_0042);
    #4;
    check("t3_stb", 32'(o_wb_stb), 32'd1);
    check("t3_adr", o_wb_adr, 32'h2000_0040);
    check("t3_valid", 32'(o_valid), 32'd0);
    for (int i = 0; i < 2; i++) begin
      run(1); #4; check("t3_stale", 32'(o_valid), 32'd0);
    end
    run(12);

    // stall held on one request
    lat_min = 1; lat_max = 1;
    stall_addr = 32'h1000_0008; stall_left = 5;
    a0 = acc_stall;
    do_reset(32'h1000_0000);
    run(14); #4;
    check("t4_single_accept", acc_stall - a0, 32'd1);
    check("t4_stall_used", stall_left, 32'd0);
    stall_addr = 32'hFFFF_FFFF;
    run(1);

    // bus error halts issue until redirect
    err_mode = 1; err_addr = 32'h1000_0004;
    do_reset(32'h1000_0000);
    run(8); #4;
    check("t5_halt_stb", 32'(o_wb_stb), 32'd0);
    check("t5_halt_cyc", 32'(o_wb_cyc), 32'd0);
    run(1); #4;
    check("t5_halt_stb2", 32'(o_wb_stb), 32'd0);
    run(1);
    redirect(32'h3000_0000);
    #4;
    check("t5_resume_stb", 32'(o_wb_stb), 32'd1);
    check("t5_resume_adr", o_wb_adr, 32'h3000_0000);
    run(8);
    err_mode = 0;

    // reset mid-burst
    lat_min = 3; lat_max = 3;
    do_reset(32'h1000_0000);
    run(4);
    do_reset(32'h1000_0100);
    #4;
    check("t6_stb", 32'(o_wb_stb), 32'd1);
    check("t6_adr", o_wb_adr, 32'h1000_0100);
    run(12);

    // randomized traffic
    err_mode = 2; lat_min = 1; lat_max = 4; stall_pct = 25;
    do_reset($urandom & 32'hFFFF_FFFC);
    for (int c = 0; c < 3000; c++) begin
      i_ready = ($urandom_range(99) < 70);
      if (c == 1500) begin
        do_reset($urandom);
      end else if ($urandom_range(99) < 3) begin
        t = ($urandom_range(9) == 0) ? (32'hFFFF_FFE0 | ($urandom & 32'h1F)) : $urandom;
        i_redirect = 1'b1; i_redirect_pc = t;
        expect_stream(t);
      end else begin
        i_redirect = 1'b0;
      end
      run(1);
    end
    i_redirect = 1'b0; i_ready = 1'b1;
    run(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
